// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per cycle, LSB first, IDLE/RUN/DONE FSM.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output o_ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Bin,
  output logic [WIDTH-1:0] o_D,
  output logic             o_Bout,
  output logic             o_busy,
  output logic             o_done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             bor_q;
  logic [CW-1:0]    cnt_q;

  logic             d;
  logic             bor_nx;
  logic             last;
  logic [WIDTH:0]   cat;

  always_comb begin
    d      = a_q[0] ^ b_q[0] ^ bor_q;
    bor_nx = (~a_q[0] & b_q[0])
           | (~(a_q[0] ^ b_q[0]) & bor_q);
    cat    = {d, res_q};
    last   = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) state_nx = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands shift right so bit 0 is always the current bit;
  // on the last bit a_q[0]/b_q[0] are the original MSBs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      bor_q  <= 1'b0;
      cnt_q  <= '0;
      o_D    <= '0;
      o_Bout <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      o_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_q   <= i_A;
            b_q   <= i_B;
            bor_q <= i_Bin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          bor_q <= bor_nx;
          res_q <= cat[WIDTH:1];
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            o_D    <= cat[WIDTH:1];
            o_Bout <= bor_nx;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            o_ovf  <= (a_q[0] ^ b_q[0]) & (d ^ a_q[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor, WIDTH=8.
// Covers reset, latency, borrow, hold, ignored start, mid-run reset.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_A    (a),
    .i_B    (b),
    .i_Bin  (bin),
    .o_D    (d),
    .o_Bout (bout),
    .o_busy (busy),
    .o_done (done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .o_ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and wait (bounded) for o_done.
  task automatic do_op(
    input  logic [W-1:0] xa,
    input  logic [W-1:0] xb,
    input  logic         xbin,
    output int           cyc,
    output logic         seen
  );
    a     = xa;
    b     = xb;
    bin   = xbin;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 20) begin
      if (done) seen = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) step();
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_d: got %h want 00", d);
    end
    checks++;
    if ({bout, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {bout, busy, done});
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_op(
    input string        name,
    input logic [W-1:0] xa,
    input logic [W-1:0] xb,
    input logic         xbin,
    input logic [W-1:0] ed,
    input logic         eb,
    input logic         eo
  );
    int   cyc;
    logic seen;
    do_op(xa, xb, xbin, cyc, seen);
    checks++;
    if (!seen || cyc != 8) begin
      errors++;
      $display("FAIL %s_latency: got seen=%b cyc=%0d want 1/8",
               name, seen, cyc);
    end
    checks++;
    if (d !== ed || bout !== eb) begin
      errors++;
      $display("FAIL %s_result: got %h/%b want %h/%b",
               name, d, bout, ed, eb);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checks++;
    if (ovf !== eo) begin
      errors++;
      $display("FAIL %s_ovf: got %b want %b", name, ovf, eo);
    end
`else
    if (eo === 1'bx) $display("note: no ovf port");
`endif
    step();
    checks++;
    if (done !== 1'b0 || d !== ed) begin
      errors++;
      $display("FAIL %s_hold: got done=%b d=%h want 0/%h",
               name, done, d, ed);
    end
  endtask

  task automatic test_ignore_start();
    int   cyc;
    int   bad;
    logic seen;
    a     = 8'h5A;
    b     = 8'h3C;
    bin   = 1'b0;
    start = 1'b1;
    step();
    a   = 8'h00;
    b   = 8'h01;
    bin = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || d !== 8'h7F) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ign_run: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (done !== 1'b1 || d !== 8'h1E || bout !== 1'b0) begin
      errors++;
      $display("FAIL ign_first: got %b %h/%b want 1 1e/0",
               done, d, bout);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle: got busy=%b done=%b want 0/0",
               busy, done);
    end
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_restart: got busy=%b want 1", busy);
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (done) seen = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    checks++;
    if (!seen || cyc != 8 || d !== 8'hFE || bout !== 1'b1) begin
      errors++;
      $display("FAIL ign_second: got %b/%0d %h/%b want 1/8 fe/1",
               seen, cyc, d, bout);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int pulses;
    a     = 8'h33;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d !== 8'h00) begin
      errors++;
      $display("FAIL rmid_clear: got %b %b %h want 0 0 00",
               busy, done, d);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rmid_nodone: got %0d pulses want 0", pulses);
    end
    test_op("rmid_fresh", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic seen;
    do_op(8'hA0, 8'h0B, 1'b0, cyc, seen);
    checks++;
    if (!seen || d !== 8'h95 || bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got %b %h/%b want 1 95/0",
               seen, d, bout);
    end
    step();
    do_op(8'h0B, 8'hA0, 1'b0, cyc, seen);
    checks++;
    if (!seen || cyc != 8 || d !== 8'h6B || bout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got %b/%0d %h/%b want 1/8 6b/1",
               seen, cyc, d, bout);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    test_op("borrow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    test_op("bin", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    test_op("ovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have a parameter WIDTH, default 8, setting the operand and result width in bits; legal values are 1 to 64.
REQ-002 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port i_start, input, 1 bit: start request, sampled only in IDLE.
REQ-005 The module SHALL have port i_A, input, WIDTH bits: the minuend.
REQ-006 The module SHALL have port i_B, input, WIDTH bits: the subtrahend.
REQ-007 The module SHALL have port i_Bin, input, 1 bit: the borrow-in for chaining.
REQ-008 The module SHALL have port o_D, output, WIDTH bits: the difference, i_A - i_B - i_Bin modulo 2^WIDTH.
REQ-009 The module SHALL have port o_Bout, output, 1 bit: the borrow-out of the MSB stage.
REQ-010 The module SHALL have port o_busy, output, 1 bit: high while the block is in RUN.
REQ-011 The module SHALL have port o_done, output, 1 bit: a one-cycle pulse marking the result valid.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE with i_start=1, the block SHALL latch i_A, i_B and i_Bin, clear the bit counter, and enter RUN on the next edge.
REQ-014 In RUN, the block SHALL process exactly one bit per cycle, LSB first: d = a^b^bor, bor_next = (~a&b) | (~(a^b)&bor).
REQ-015 The first RUN cycle SHALL use the latched i_Bin as bor.
REQ-016 Each d bit SHALL shift into a result register from the MSB end, so that the result is LSB-aligned after WIDTH shifts.
REQ-017 After exactly WIDTH RUN cycles the FSM SHALL enter DONE; the bit counter is $clog2(WIDTH)+1 bits wide.
REQ-018 In DONE, the block SHALL hold o_done=1 for one cycle, update o_D and o_Bout in that cycle, then return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: for a start sampled at edge k, RUN spans cycles k+1..k+WIDTH and o_done is high in cycle k+WIDTH+1.
REQ-020 o_D and o_Bout SHALL hold their values from o_done until the DONE cycle of the next operation; they SHALL NOT change during RUN.
REQ-021 i_start SHALL be ignored in RUN and DONE, with no queuing.
REQ-022 Changes to i_A, i_B and i_Bin after latching SHALL have no effect on the operation in progress.
REQ-023 With WIDTH=1, the block SHALL spend one RUN cycle, and o_done SHALL assert two cycles after the start edge.
REQ-024 Back-to-back operation SHALL be supported: a start sampled in the IDLE cycle immediately following DONE is accepted.

Reset
REQ-025 On i_rst=1 at a clock edge, the FSM SHALL go to IDLE and clear the counter, borrow register and operand registers.
REQ-026 Reset values SHALL be o_D=0, o_Bout=0, o_busy=0 and o_done=0.
REQ-027 Reset SHALL take priority over i_start and over any in-progress operation.
REQ-028 An operation interrupted by reset SHALL be abandoned, with no o_done pulse.
REQ-029 A start SHALL be accepted in the first IDLE cycle after i_rst is deasserted.

Configuration
REQ-030 Macro SERIAL_SUBTRACTOR_OVF_EN, when defined, SHALL add output port o_ovf (1 bit): signed two's-complement overflow, defined as (a_msb != b_msb) && (d_msb != a_msb).
REQ-031 With SERIAL_SUBTRACTOR_OVF_EN defined, o_ovf SHALL be updated in DONE, held like o_D, and reset to 0.
REQ-032 Without SERIAL_SUBTRACTOR_OVF_EN, the o_ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-033 Bench SHALL cover: i_A=0x5A, i_B=0x3C, i_Bin=0, start -> o_done in cycle k+9 with o_D=0x1E and o_Bout=0.
REQ-034 Bench SHALL cover: i_A=0x00, i_B=0x01, i_Bin=0 -> o_D=0xFF, o_Bout=1; with the macro defined, o_ovf=0.
REQ-035 Bench SHALL cover: i_A=0x10, i_B=0x0F, i_Bin=1 -> o_D=0x00, o_Bout=0.
REQ-036 Bench SHALL cover, with the macro defined: i_A=0x80, i_B=0x01 -> o_D=0x7F, o_Bout=0, o_ovf=1.
REQ-037 Bench SHALL cover: start, then i_start held high plus new operands during RUN -> a single o_done carrying the first result, and the next start accepted only in IDLE.
REQ-038 Bench SHALL cover: i_rst=1 in the 4th RUN cycle -> next cycle o_busy=0, o_D=0, and no o_done; a fresh start then yields a correct result.
